// File: rtl/prathama_pkg.sv
// Shared types and constants for the Prathama execute-stage dispatcher.
// Unit select codes, dispatcher state encoding and timer sizing live here.
package prathama_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned TMR_W        = 8;

    typedef enum logic [1:0] {
        UNIT_LOGIC   = 2'd0,
        UNIT_ARITH   = 2'd1,
        UNIT_SHIFT   = 2'd2,
        UNIT_ILLEGAL = 2'd3
    } unit_sel_e;

    typedef enum logic [2:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_WB
    } disp_state_e;

endpackage

// File: rtl/dispatch_timer.sv
// Loadable down-counter shared by the post-reset drain and the wait timeout.
// zero flags the decrement that takes the count from one to zero.
module dispatch_timer
    import prathama_pkg::*;
#(
    parameter int unsigned     W       = TMR_W,
    parameter logic [W-1:0]    RST_VAL = W'(DRAIN_CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    // Firing on the last step lets a load of N bound a state to exactly N cycles.
    assign zero = dec && (count_q == W'(1));

endmodule

// File: rtl/exec_dispatch.sv
// Execute-stage dispatcher: issues one decoded instruction to the logic, arith
// or shift unit, follows its rdy handshake and writes the result back.
module exec_dispatch
    import prathama_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       unit_sel,
    input  logic [1:0]       op_sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       dst_in,
    output logic             cs_logic,
    output logic             cs_arith,
    output logic             cs_shift,
    output logic [1:0]       op_sub,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [2:0]       unit_rdy,
    input  logic [WIDTH-1:0] res_d,
    output logic             wb_en,
    output logic [2:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             err
);

    disp_state_e state_q, state_d;
    unit_sel_e   sel_q;
    logic [2:0]  dst_q;
    logic        sel_rdy;
    logic        accept, illegal, capture, abort;
    logic        tmr_clr, tmr_load, tmr_dec, tmr_zero;

    dispatch_timer #(
        .W       (TMR_W),
        .RST_VAL (TMR_W'(DRAIN_CYCLES))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (TMR_W'(TIMEOUT)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        sel_rdy = 1'b0;
        case (sel_q)
            UNIT_LOGIC: sel_rdy = unit_rdy[0];
            UNIT_ARITH: sel_rdy = unit_rdy[1];
            UNIT_SHIFT: sel_rdy = unit_rdy[2];
            default:    sel_rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        illegal  = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (instr_valid) begin
                    accept = 1'b1;
                    if (unit_sel == UNIT_ILLEGAL) illegal = 1'b1;
                    else                          state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_load = 1'b1;
                state_d  = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                tmr_dec = 1'b1;
                if (!sel_rdy) begin
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT_HIGH;
                end else if (tmr_zero) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                tmr_dec = 1'b1;
                // rdy is tested first so a late completion beats the timeout.
                if (sel_rdy) begin
                    capture = 1'b1;
                    state_d = ST_WB;
                end else if (tmr_zero) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DRAIN;
            sel_q   <= UNIT_LOGIC;
            op_sub  <= '0;
            a_out   <= '0;
            b_out   <= '0;
            dst_q   <= '0;
            wb_data <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            err     <= illegal | abort;
            // Operands only move on accept, so they hold from ISSUE through WB.
            if (accept) begin
                sel_q  <= unit_sel_e'(unit_sel);
                op_sub <= op_sub_in;
                a_out  <= a_in;
                b_out  <= b_in;
                dst_q  <= dst_in;
            end
            if (capture) wb_data <= res_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign cs_logic    = (state_q == ST_ISSUE) && (sel_q == UNIT_LOGIC);
    assign cs_arith    = (state_q == ST_ISSUE) && (sel_q == UNIT_ARITH);
    assign cs_shift    = (state_q == ST_ISSUE) && (sel_q == UNIT_SHIFT);
    assign wb_en       = (state_q == ST_WB);
    assign wb_addr     = dst_q;

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed bench for exec_dispatch with behavioural logic/arith/shift units
// on the shared result bus; expected results are hand-computed constants.
module tb_exec_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  unit_sel = '0;
    logic [1:0]  op_sub_in = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [2:0]  dst_in = '0;
    logic        cs_logic, cs_arith, cs_shift;
    logic [1:0]  op_sub;
    logic [15:0] a_out, b_out;
    logic [15:0] res_d;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;

    logic [2:0]  urdy = 3'b111;
    logic [2:0]  stuck = 3'b000;
    int          ucnt [3] = '{default: 0};
    int          unit_lat = 1;
    logic        udrv = 1'b0;
    logic [15:0] ures = '0;
    logic [2:0]  cs_vec;

    int n_checks = 0;
    int n_errors = 0;

    exec_dispatch #(.WIDTH(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .unit_sel    (unit_sel),
        .op_sub_in   (op_sub_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .dst_in      (dst_in),
        .cs_logic    (cs_logic),
        .cs_arith    (cs_arith),
        .cs_shift    (cs_shift),
        .op_sub      (op_sub),
        .a_out       (a_out),
        .b_out       (b_out),
        .unit_rdy    (urdy),
        .res_d       (res_d),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign cs_vec = {cs_shift, cs_arith, cs_logic};
    // Undriven bus reads as junk so a sample at the wrong time is visible.
    assign res_d = udrv ? ures : 16'hDEAD;

    function automatic logic [15:0] unit_fn(input int u, input logic [1:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        case (u)
            0: case (op)
                   2'd0: r = ~(a & b);
                   2'd1: r = a ^ b;
                   2'd2: r = ~a;
                   default: r = a & b;
               endcase
            1: r = op[0] ? (a - b) : (a + b);
            default: r = op[0] ? (a >> b[3:0]) : (a << b[3:0]);
        endcase
        return r;
    endfunction

    // Units: rdy drops on the chip-select edge, rises unit_lat edges later
    // with the result driven on the bus for that one cycle. No reset.
    always @(posedge clk) begin
        udrv <= 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stuck[i]) begin
                urdy[i] <= 1'b1;
            end else if (ucnt[i] > 0) begin
                ucnt[i] <= ucnt[i] - 1;
                if (ucnt[i] == 1) begin
                    urdy[i] <= 1'b1;
                    udrv    <= 1'b1;
                    ures    <= unit_fn(i, op_sub, a_out, b_out);
                end
            end else if (cs_vec[i]) begin
                urdy[i] <= 1'b0;
                ucnt[i] <= unit_lat;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        tick(); check({tag, ":drain1"}, instr_ready, 1'b0);
        tick(); check({tag, ":drain2"}, instr_ready, 1'b0);
        tick(); check({tag, ":drain3"}, instr_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":ctl"}, {instr_ready, cs_vec, wb_en, err}, 6'b0);
        check({tag, ":ops"}, {op_sub, a_out, b_out}, 34'h0);
        check({tag, ":wb"}, {wb_addr, wb_data}, 19'h0);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst);
        instr_valid = 1'b1;
        unit_sel    = sel;
        op_sub_in   = op;
        a_in        = a;
        b_in        = b;
        dst_in      = dst;
    endtask

    task automatic run_op(input string tag, input logic [1:0] sel, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst,
                          input int lat, input logic [15:0] exp);
        int k;
        k = 0;
        while (!instr_ready && k < 20) begin
            tick();
            k++;
        end
        check({tag, ":ready"}, instr_ready, 1'b1);
        unit_lat = lat;
        drive(sel, op, a, b, dst);
        tick();
        instr_valid = 1'b0;
        a_in = ~a;
        b_in = ~b;
        op_sub_in = ~op;
        check({tag, ":issue"}, {cs_vec, err, instr_ready}, {3'b001 << sel, 2'b00});
        check({tag, ":opnd"}, {op_sub, a_out, b_out}, {op, a, b});
        for (int t = 1; t <= 2 + lat; t++) begin
            tick();
            check({tag, ":hold"}, {cs_vec, err, wb_en, op_sub, a_out, b_out},
                  {3'b000, 1'b0, logic'(t == 2 + lat), op, a, b});
        end
        check({tag, ":wbdata"}, wb_data, exp);
        check({tag, ":wbaddr"}, wb_addr, dst);
        tick();
        check({tag, ":idle"}, {wb_en, err, instr_ready}, 3'b001);
    endtask

    task automatic timeout_op(input string tag, input logic [1:0] sel,
                              input int lat, input int t_abort);
        unit_lat = lat;
        drive(sel, 2'd0, 16'h1111, 16'h0001, 3'd6);
        tick();
        instr_valid = 1'b0;
        check({tag, ":issue"}, cs_vec, 3'b001 << sel);
        for (int t = 1; t < t_abort; t++) begin
            tick();
            check({tag, ":wait"}, {cs_vec, err, wb_en, instr_ready}, 6'b0);
        end
        tick();
        check({tag, ":abort"}, {err, wb_en, instr_ready}, 3'b101);
        tick();
        check({tag, ":after"}, {err, wb_en, instr_ready}, 3'b001);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain_check("init");

        // 0x0FFF = NAND(F0F0, FF00)
        run_op("nand", 2'd0, 2'd0, 16'hF0F0, 16'hFF00, 3'd5, 1, 16'h0FFF);
        run_op("xor",  2'd0, 2'd1, 16'hF0F0, 16'hFF00, 3'd1, 1, 16'h0FF0);
        run_op("not",  2'd0, 2'd2, 16'hF0F0, 16'hFF00, 3'd2, 1, 16'h0F0F);

        drive(2'd3, 2'd0, 16'hAAAA, 16'h5555, 3'd4);
        tick();
        instr_valid = 1'b0;
        check("illegal", {err, cs_vec, wb_en, instr_ready}, 6'b100001);
        run_op("add_after_ill", 2'd1, 2'd0, 16'h1234, 16'h4321, 3'd3, 1, 16'h5555);

        // rdy rises on the last allowed WAIT_HIGH cycle: capture, no err
        run_op("sub_late", 2'd1, 2'd1, 16'h1000, 16'h0001, 3'd4, 15, 16'h0FFF);
        run_op("shl", 2'd2, 2'd0, 16'h0001, 16'h0004, 3'd6, 2, 16'h0010);

        stuck = 3'b001;
        timeout_op("to_low", 2'd0, 1, 16);
        stuck = 3'b000;
        timeout_op("to_high", 2'd2, 16, 17);

        unit_lat = 3;
        drive(2'd2, 2'd0, 16'h0003, 16'h0001, 3'd7);
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check("rst_pre", {cs_vec, wb_en, instr_ready, a_out}, {5'b0, 16'h0003});
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain_check("rst");
        run_op("shr_post_rst", 2'd2, 2'd1, 16'h8000, 16'h000F, 3'd7, 1, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
